ds_scoreboard: RTL and testbench

- Parametrised register-hazard scoreboard for the decode stage of the pipelined CPU.
- Replaces fixed per-stage destination compares with per-register in-flight counters, so pipeline depth can grow without rewiring the decode stage.
- Counts instructions issued from decode (ds->es handshake) and retired at writeback, and tracks in-flight loads separately.
- Produces per-source busy flags and one decode stall, in forwarding or non-forwarding mode.

---
 rtl/ds_scoreboard_if.sv | 37 +++
 rtl/ds_scoreboard.sv | 124 ++++++++++++
 tb/tb_ds_scoreboard.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ds_scoreboard_if.sv
// Decode-stage scoreboard bus: issue/retire/flush handshakes and per-source hazard query.
// The master side is the decode/writeback logic; the slave side is the scoreboard.
interface ds_scoreboard_if #(
  parameter int AW      = 5,
  parameter int NUM_SRC = 3
);
  logic                   issue_valid;
  logic                   issue_ready;
  logic                   issue_we;
  logic [AW-1:0]          issue_dest;
  logic                   issue_is_load;
  logic                   retire_valid;
  logic                   retire_we;
  logic [AW-1:0]          retire_dest;
  logic                   retire_is_load;
  logic                   flush;
  logic [NUM_SRC*AW-1:0]  src_addr;
  logic [NUM_SRC-1:0]     src_used;
  logic [NUM_SRC-1:0]     src_busy;
  logic [NUM_SRC-1:0]     src_load_busy;
  logic                   stall;
  logic                   pending_any;

  modport master (
    output issue_valid, issue_we, issue_dest, issue_is_load,
    output retire_valid, retire_we, retire_dest, retire_is_load,
    output flush, src_addr, src_used,
    input  issue_ready, src_busy, src_load_busy, stall, pending_any
  );

  modport slave (
    input  issue_valid, issue_we, issue_dest, issue_is_load,
    input  retire_valid, retire_we, retire_dest, retire_is_load,
    input  flush, src_addr, src_used,
    output issue_ready, src_busy, src_load_busy, stall, pending_any
  );
endinterface

// File: rtl/ds_scoreboard.sv
// Register-hazard scoreboard: per-register in-flight writer and load counters with
// same-cycle retire bypass, producing per-source busy flags and the decode stall.
module ds_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int AW       = 5,
  parameter int NUM_SRC  = 3,
  parameter int CNT_W    = 2,
  parameter bit FWD_EN   = 1'b1
) (
  input  logic            clk,
  input  logic            resetn,
  ds_scoreboard_if.slave  sb
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] pendCnt_q [1:NUM_REGS-1];
  logic [CNT_W-1:0] pendCnt_d [1:NUM_REGS-1];
  logic [CNT_W-1:0] loadCnt_q [1:NUM_REGS-1];
  logic [CNT_W-1:0] loadCnt_d [1:NUM_REGS-1];
  logic [CNT_W-1:0] effPend   [NUM_REGS];
  logic [CNT_W-1:0] effLoad   [NUM_REGS];

  logic               iss;
  logic               ret;
  logic               issueReady;
  logic [NUM_SRC-1:0] srcBusy;
  logic [NUM_SRC-1:0] srcLoadBusy;
  logic               pendingAny;

  // Effective counts see a same-cycle retire so a source whose last writer is
  // committing now is already free; register 0 reads as permanently idle.
  always_comb begin
    ret        = sb.retire_valid & sb.retire_we & (sb.retire_dest != '0);
    effPend[0] = '0;
    effLoad[0] = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      effPend[r] = pendCnt_q[r];
      effLoad[r] = loadCnt_q[r];
      if (ret && (sb.retire_dest == AW'(r))) begin
        if (pendCnt_q[r] != '0)
          effPend[r] = pendCnt_q[r] - CNT_W'(1);
        if (sb.retire_is_load && (loadCnt_q[r] != '0))
          effLoad[r] = loadCnt_q[r] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    issueReady = ~(sb.issue_we && (sb.issue_dest != '0) && (effPend[sb.issue_dest] == CNT_MAX));
    iss        = sb.issue_valid & issueReady & sb.issue_we & (sb.issue_dest != '0);
  end

  always_comb begin
    srcBusy     = '0;
    srcLoadBusy = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sb.src_used[i] && (sb.src_addr[i*AW +: AW] != '0)) begin
        srcBusy[i]     = (effPend[sb.src_addr[i*AW +: AW]] != '0);
        srcLoadBusy[i] = (effLoad[sb.src_addr[i*AW +: AW]] != '0);
      end
    end
    pendingAny = 1'b0;
    for (int r = 1; r < NUM_REGS; r++)
      pendingAny = pendingAny | (pendCnt_q[r] != '0);
  end

  assign sb.issue_ready   = issueReady;
  assign sb.src_busy      = srcBusy;
  assign sb.src_load_busy = srcLoadBusy;
  assign sb.stall         = FWD_EN ? (|srcLoadBusy) : (|srcBusy);
  assign sb.pending_any   = pendingAny;

  // Issue and retire on the same register cancel; decrements hold at zero and
  // increments cannot overflow because a saturated issue is refused upstream.
  always_comb begin
    for (int r = 1; r < NUM_REGS; r++) begin
      pendCnt_d[r] = pendCnt_q[r];
      loadCnt_d[r] = loadCnt_q[r];
      if (sb.flush) begin
        pendCnt_d[r] = '0;
        loadCnt_d[r] = '0;
      end else begin
        if (iss && (sb.issue_dest == AW'(r)) && !(ret && (sb.retire_dest == AW'(r))))
          pendCnt_d[r] = pendCnt_q[r] + CNT_W'(1);
        else if (ret && (sb.retire_dest == AW'(r)) && !(iss && (sb.issue_dest == AW'(r))))
          pendCnt_d[r] = (pendCnt_q[r] != '0) ? pendCnt_q[r] - CNT_W'(1) : '0;

        if (iss && sb.issue_is_load && (sb.issue_dest == AW'(r)) &&
            !(ret && sb.retire_is_load && (sb.retire_dest == AW'(r)))) begin
          if (loadCnt_q[r] != CNT_MAX)
            loadCnt_d[r] = loadCnt_q[r] + CNT_W'(1);
        end else if (ret && sb.retire_is_load && (sb.retire_dest == AW'(r)) &&
                     !(iss && sb.issue_is_load && (sb.issue_dest == AW'(r)))) begin
          loadCnt_d[r] = (loadCnt_q[r] != '0) ? loadCnt_q[r] - CNT_W'(1) : '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        pendCnt_q[r] <= '0;
        loadCnt_q[r] <= '0;
      end
    end else begin
      pendCnt_q <= pendCnt_d;
      loadCnt_q <= loadCnt_d;
    end
  end

  // A retire with nothing in flight means decode and writeback disagree.
  always @(posedge clk) begin
    if (resetn && !sb.flush && ret) begin
      assert (pendCnt_q[sb.retire_dest] != '0)
        else $error("ds_scoreboard: retire underflow on r%0d", sb.retire_dest);
      if (sb.retire_is_load)
        assert (loadCnt_q[sb.retire_dest] != '0)
          else $error("ds_scoreboard: load retire underflow on r%0d", sb.retire_dest);
    end
  end

endmodule

// File: tb/tb_ds_scoreboard.sv
// Directed bench for ds_scoreboard: the same stimulus drives a forwarding and a
// non-forwarding instance, checked against a counter model through an expectation queue.
module tb_ds_scoreboard;

  localparam int AW = 5;
  localparam int NS = 3;

  typedef struct {
    logic          issueReady;
    logic [NS-1:0] busy;
    logic [NS-1:0] loadBusy;
    logic          stallFwd;
    logic          stallNoFwd;
    logic          pendingAny;
  } expT;

  logic clk;
  logic resetn;

  logic          issueValid, issueWe, issueIsLoad;
  logic [AW-1:0] issueDest;
  logic          retireValid, retireWe, retireIsLoad;
  logic [AW-1:0] retireDest;
  logic          flushIn;
  logic [AW-1:0] srcA [NS];
  logic [NS-1:0] srcUsed;

  int pendM [32];
  int loadM [32];
  expT expQ [$];
  int checks = 0;
  int errors = 0;

  ds_scoreboard_if #(.AW(AW), .NUM_SRC(NS)) sbFwd ();
  ds_scoreboard_if #(.AW(AW), .NUM_SRC(NS)) sbNoFwd ();

  ds_scoreboard #(.NUM_REGS(32), .AW(AW), .NUM_SRC(NS), .CNT_W(2), .FWD_EN(1'b1)) dutFwd (
    .clk(clk), .resetn(resetn), .sb(sbFwd.slave)
  );
  ds_scoreboard #(.NUM_REGS(32), .AW(AW), .NUM_SRC(NS), .CNT_W(2), .FWD_EN(1'b0)) dutNoFwd (
    .clk(clk), .resetn(resetn), .sb(sbNoFwd.slave)
  );

  assign sbFwd.issue_valid    = issueValid;
  assign sbFwd.issue_we       = issueWe;
  assign sbFwd.issue_dest     = issueDest;
  assign sbFwd.issue_is_load  = issueIsLoad;
  assign sbFwd.retire_valid   = retireValid;
  assign sbFwd.retire_we      = retireWe;
  assign sbFwd.retire_dest    = retireDest;
  assign sbFwd.retire_is_load = retireIsLoad;
  assign sbFwd.flush          = flushIn;
  assign sbFwd.src_addr       = {srcA[2], srcA[1], srcA[0]};
  assign sbFwd.src_used       = srcUsed;
  assign sbNoFwd.issue_valid    = issueValid;
  assign sbNoFwd.issue_we       = issueWe;
  assign sbNoFwd.issue_dest     = issueDest;
  assign sbNoFwd.issue_is_load  = issueIsLoad;
  assign sbNoFwd.retire_valid   = retireValid;
  assign sbNoFwd.retire_we      = retireWe;
  assign sbNoFwd.retire_dest    = retireDest;
  assign sbNoFwd.retire_is_load = retireIsLoad;
  assign sbNoFwd.flush          = flushIn;
  assign sbNoFwd.src_addr       = {srcA[2], srcA[1], srcA[0]};
  assign sbNoFwd.src_used       = srcUsed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int effP(int r);
    int v;
    if (r == 0) return 0;
    v = pendM[r];
    if (retireValid && retireWe && retireDest == AW'(r) && v > 0) v--;
    return v;
  endfunction

  function automatic int effL(int r);
    int v;
    if (r == 0) return 0;
    v = loadM[r];
    if (retireValid && retireWe && retireIsLoad && retireDest == AW'(r) && v > 0) v--;
    return v;
  endfunction

  function automatic expT modelExpect();
    expT e;
    e.issueReady = !(issueWe && issueDest != 0 && effP(int'(issueDest)) == 3);
    e.busy       = '0;
    e.loadBusy   = '0;
    for (int i = 0; i < NS; i++) begin
      e.busy[i]     = srcUsed[i] && srcA[i] != 0 && effP(int'(srcA[i])) != 0;
      e.loadBusy[i] = srcUsed[i] && srcA[i] != 0 && effL(int'(srcA[i])) != 0;
    end
    e.stallFwd   = |e.loadBusy;
    e.stallNoFwd = |e.busy;
    e.pendingAny = 1'b0;
    for (int r = 1; r < 32; r++)
      if (pendM[r] != 0) e.pendingAny = 1'b1;
    return e;
  endfunction

  task automatic compareVal(input string tag, input logic [NS-1:0] obs, input logic [NS-1:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
  endtask

  task automatic applyStimulus(input logic iv, input logic iwe, input int idest, input logic il,
                               input logic rv, input logic rwe, input int rdest, input logic rl,
                               input logic fl, input int a0, input int a1, input int a2,
                               input logic [NS-1:0] used);
    issueValid = iv;  issueWe = iwe;  issueDest = AW'(idest);  issueIsLoad = il;
    retireValid = rv; retireWe = rwe; retireDest = AW'(rdest); retireIsLoad = rl;
    flushIn = fl;
    srcA[0] = AW'(a0); srcA[1] = AW'(a1); srcA[2] = AW'(a2);
    srcUsed = used;
  endtask

  // Expected values are queued as the stimulus settles and retired against the DUT outputs.
  task automatic checkOutput(input string tag);
    expT e;
    #1;
    expQ.push_back(modelExpect());
    e = expQ.pop_front();
    compareVal({tag, ".fwd.issue_ready"},   NS'(sbFwd.issue_ready),   NS'(e.issueReady));
    compareVal({tag, ".fwd.src_busy"},      sbFwd.src_busy,           e.busy);
    compareVal({tag, ".fwd.src_load_busy"}, sbFwd.src_load_busy,      e.loadBusy);
    compareVal({tag, ".fwd.stall"},         NS'(sbFwd.stall),         NS'(e.stallFwd));
    compareVal({tag, ".fwd.pending_any"},   NS'(sbFwd.pending_any),   NS'(e.pendingAny));
    compareVal({tag, ".nofwd.issue_ready"}, NS'(sbNoFwd.issue_ready), NS'(e.issueReady));
    compareVal({tag, ".nofwd.src_busy"},    sbNoFwd.src_busy,         e.busy);
    compareVal({tag, ".nofwd.stall"},       NS'(sbNoFwd.stall),       NS'(e.stallNoFwd));
    compareVal({tag, ".nofwd.pending_any"}, NS'(sbNoFwd.pending_any), NS'(e.pendingAny));
  endtask

  // Apply one clock edge to the model using the inputs that were held across it.
  task automatic advanceClock();
    logic ready;
    logic iss;
    logic ret;
    ready = !(issueWe && issueDest != 0 && effP(int'(issueDest)) == 3);
    iss   = issueValid && ready && issueWe && issueDest != 0;
    ret   = retireValid && retireWe && retireDest != 0;
    @(posedge clk);
    if (flushIn) begin
      for (int r = 0; r < 32; r++) begin
        pendM[r] = 0;
        loadM[r] = 0;
      end
    end else begin
      if (iss) pendM[issueDest]++;
      if (iss && issueIsLoad) loadM[issueDest]++;
      if (ret && pendM[retireDest] > 0) pendM[retireDest]--;
      if (ret && retireIsLoad && loadM[retireDest] > 0) loadM[retireDest]--;
    end
    @(negedge clk);
  endtask

  task automatic idleStep(input string tag, input int a0, input logic [NS-1:0] used);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, a0, 0, 0, used);
    checkOutput(tag);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      pendM[r] = 0;
      loadM[r] = 0;
    end
    resetn = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 7, 3, 3'b111);
    @(negedge clk);
    checkOutput("reset");
    @(negedge clk);
    resetn = 1'b1;

    applyStimulus(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    checkOutput("issue5");
    advanceClock();
    idleStep("busy5", 5, 3'b001);

    applyStimulus(1, 1, 7, 1, 0, 0, 0, 0, 0, 5, 0, 0, 3'b001);
    checkOutput("issueLoad7");
    advanceClock();
    idleStep("loadBusy7", 7, 3'b001);
    applyStimulus(0, 0, 0, 0, 1, 1, 7, 1, 0, 7, 0, 0, 3'b001);
    checkOutput("retire7Bypass");
    advanceClock();
    idleStep("after7", 7, 3'b001);
    applyStimulus(0, 0, 0, 0, 1, 1, 5, 0, 0, 5, 0, 0, 3'b001);
    checkOutput("retire5");
    advanceClock();

    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 3, 0, 0, 0, 0, 0, 0, 3, 0, 0, 3'b001);
      checkOutput($sformatf("issue3_%0d", k));
      advanceClock();
    end
    applyStimulus(1, 1, 3, 0, 0, 0, 0, 0, 0, 3, 4, 0, 3'b011);
    checkOutput("saturated3");
    advanceClock();
    applyStimulus(0, 1, 4, 0, 0, 0, 0, 0, 0, 3, 0, 0, 3'b001);
    checkOutput("ready4");
    applyStimulus(1, 1, 3, 0, 1, 1, 3, 0, 0, 3, 0, 0, 3'b001);
    checkOutput("issueRetire3");
    advanceClock();
    applyStimulus(0, 1, 3, 0, 0, 0, 0, 0, 0, 3, 0, 0, 3'b001);
    checkOutput("still3");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 0, 1, 1, 3, 0, 0, 3, 0, 0, 3'b001);
      checkOutput($sformatf("drain3_%0d", k));
      advanceClock();
    end

    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001);
    checkOutput("issue0");
    advanceClock();
    idleStep("after0", 0, 3'b001);

    applyStimulus(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    advanceClock();
    applyStimulus(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    advanceClock();
    applyStimulus(1, 1, 9, 1, 0, 0, 0, 0, 0, 2, 9, 9, 3'b111);
    checkOutput("preFlush");
    advanceClock();
    applyStimulus(1, 1, 11, 0, 0, 0, 0, 0, 1, 2, 9, 11, 3'b111);
    checkOutput("flushCycle");
    advanceClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 9, 11, 3'b111);
    checkOutput("afterFlush");

    applyStimulus(1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    advanceClock();
    idleStep("busy6", 6, 3'b001);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    for (int r = 0; r < 32; r++) begin
      pendM[r] = 0;
      loadM[r] = 0;
    end
    checkOutput("asyncReset");
    @(negedge clk);
    resetn = 1'b1;
    idleStep("postReset", 6, 3'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
